tlc_param_junction: RTL and testbench
=====================================

// Module: tlc_param_junction
// PURPOSE
//  Parametrised four-signal junction controller: M1, M2 through, MT turn, S side road.
//  Phase durations and tick prescale are parameters.
//  Outputs are registered.
//  Side-road phase is demand-driven via a latched request.
//  Optional night-flash mode.
//  Sits between the tick/clock domain and the lamp drivers.
// PARAMETERS
//  TICK_DIV  4  clk cycles per timing tick (>=1)
//  T_MG      7  ticks, M1+M2 green (>=1)
//  T_Y       2  ticks, every yellow phase (>=1)
//  T_TG      5  ticks, M1+MT green (>=1)
//  T_SG      3  ticks, S green (>=1)
//  T_AR      2  ticks, all-red clearance (>=1)
// PORTS
//  clk       in   1  system clock, rising edge
//  rst_n     in   1  async active-low reset
//  side_req  in   1  side-road demand (level or pulse)
//  flash     in   1  night-flash request (TLC_FLASH_EN only)
//  light_M1  out  3  lamp code
//  light_M2  out  3  lamp code
//  light_MT  out  3  lamp code
//  light_S   out  3  lamp code
//  phase     out  3  current state encoding
//  tick      out  1  one-cycle prescaler pulse
//  req_pend  out  1  latched side demand
// BEHAVIOUR
//  Lamp codes: 3'b001 green, 3'b010 yellow, 3'b100 red, 3'b000 dark.
//  Reset (async, rst_n=0):
//   - state=AR, all lights 3'b100, phase=5, prescaler=0, timer=T_AR-1, req_pend=0, tick=0.
//  States / lamps (M1,M2,MT,S):
//   - MG=0 (G,G,R,R)
//   - M2Y=1 (G,Y,R,R)
//   - TG=2 (G,R,G,R)
//   - TY=3 (Y,R,Y,R)
//   - SG=4 (R,R,R,G)
//   - AR=5 (R,R,R,R)
//   - FL=6 (flash)
//  Sequence: MG->M2Y->TG->TY->{SG if demand}->AR->MG. If no demand, TY->AR directly.
//  Demand at TY exit = req_pend | side_req sampled that cycle.
//  Prescaler: counts 0..TICK_DIV-1; tick=1 on the cycle it equals TICK_DIV-1.
//   - Clears to 0 on every state change, so every phase is exactly T_x*TICK_DIV clk cycles.
//  Timer: loads T_x-1 on state entry and decrements on tick. A tick with timer==0 causes the transition.
//  Outputs are registered: lamps and phase change on the same edge as state. No combinational path from inputs to lamps.
//  req_pend: set on any cycle with side_req=1, cleared on the SG entry edge.
//   - side_req during SG sets it again, giving service in the next cycle round.
//   - Set and clear in the same cycle -> clear wins. A request held high through SG entry is dropped; it re-latches the next cycle if still held.
//  Timer width: $clog2(max T_x)+1. Prescaler width: $clog2(TICK_DIV)+1. No wrap is possible.
//  Illegal state (6 without macro, or 7) -> AR on the next edge, all red.
//  rst_n asserted mid-phase: immediate all-red, sequence restarts at AR.
// CONFIGURATION
//  TLC_FLASH_EN defined:
//   - flash port exists.
//   - flash=1 sampled at a phase-end transition (any state) -> enter FL instead of the normal successor.
//   - In FL: M1, M2, MT alternate 3'b010/3'b000 and S alternates 3'b100/3'b000, toggling on each tick. Lamps start lit on FL entry.
//   - flash=0 while in FL -> AR on the next tick edge with a full T_AR timer, then MG. req_pend is kept.
//  TLC_FLASH_EN undefined:
//   - No flash port; FL is unreachable and treated as illegal.
// TESTING
//  1. Defaults; release rst_n -> 8 clk cycles all-red (AR), then MG (001,001,100,100) for 28 cycles, then M2Y for 8.
//  2. Full cycle with side_req pulsed one cycle during MG -> TG 20, TY 8, SG 12 cycles (S=001), AR 8; req_pend=0 after SG entry.
//  3. No side_req for whole cycle -> TY followed directly by AR; S never shows 001; cycle = 8+28+8+20+8 clk.
//  4. side_req held high across SG entry and through SG -> req_pend=1 from the cycle after SG entry; SG served again next round.
//  5. rst_n low for 1 cycle mid-TG -> lamps all 100 immediately (async), phase=5, tick=0, next MG after 8 cycles.
//  6. (TLC_FLASH_EN) flash=1 during MG -> at MG end enter FL, M lamps 010/000 toggle every 4 clk. flash=0 -> AR for 8 clk, then MG.

Source files
------------

// File: rtl/tlc_param_junction.sv
// Four-signal junction controller (M1/M2 through, MT turn, S side road) with prescaled phase timing.
// Optional night-flash mode is compiled in when TLC_FLASH_EN is defined.
//
// state | meaning
// MG    | M1+M2 green
// M2Y   | M2 yellow, M1 still green
// TG    | M1+MT green
// TY    | M1+MT yellow
// SG    | side road green (only on demand)
// AR    | all-red clearance
// FL    | night flash (TLC_FLASH_EN only)
module tlc_param_junction #(
  parameter int TICK_DIV = 4,
  parameter int T_MG     = 7,
  parameter int T_Y      = 2,
  parameter int T_TG     = 5,
  parameter int T_SG     = 3,
  parameter int T_AR     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
`ifdef TLC_FLASH_EN
  input  logic       flash,
`endif
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [2:0] phase,
  output logic       tick,
  output logic       req_pend
);

  localparam int T_M1  = (T_MG > T_Y)  ? T_MG : T_Y;
  localparam int T_M2  = (T_TG > T_SG) ? T_TG : T_SG;
  localparam int T_M3  = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int T_MAX = (T_M3 > T_AR) ? T_M3 : T_AR;
  localparam int TW    = $clog2(T_MAX) + 1;
  localparam int PW    = $clog2(TICK_DIV) + 1;

  localparam logic [2:0] L_G = 3'b001;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_D = 3'b000;

  typedef enum logic [2:0] {
    MG  = 3'd0,
    M2Y = 3'd1,
    TG  = 3'd2,
    TY  = 3'd3,
    SG  = 3'd4,
    AR  = 3'd5,
    FL  = 3'd6
  } state_t;

  state_t          state;
  state_t          succ;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   timer;
  logic [11:0]     lamps;
  logic            blink;
  logic            legal;
  logic            go;
  logic            flash_req;

`ifdef TLC_FLASH_EN
  assign flash_req = flash;
  localparam bit FLASH_EN = 1'b1;
`else
  assign flash_req = 1'b0;
  localparam bit FLASH_EN = 1'b0;
`endif

  function automatic logic [TW-1:0] load(state_t s);
    case (s)
      MG:      load = TW'(T_MG - 1);
      M2Y, TY: load = TW'(T_Y - 1);
      TG:      load = TW'(T_TG - 1);
      SG:      load = TW'(T_SG - 1);
      default: load = TW'(T_AR - 1);
    endcase
  endfunction

  // Lamp word is {M1, M2, MT, S}; lit only matters for the flash state.
  function automatic logic [11:0] lamp_code(state_t s, logic lit);
    case (s)
      MG:      lamp_code = {L_G, L_G, L_R, L_R};
      M2Y:     lamp_code = {L_G, L_Y, L_R, L_R};
      TG:      lamp_code = {L_G, L_R, L_G, L_R};
      TY:      lamp_code = {L_Y, L_R, L_Y, L_R};
      SG:      lamp_code = {L_R, L_R, L_R, L_G};
      FL:      lamp_code = lit ? {L_Y, L_Y, L_Y, L_R} : {L_D, L_D, L_D, L_D};
      default: lamp_code = {L_R, L_R, L_R, L_R};
    endcase
  endfunction

  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign phase    = state;
  assign {light_M1, light_M2, light_MT, light_S} = lamps;

  always_comb begin
    succ  = AR;
    legal = (state inside {MG, M2Y, TG, TY, SG, AR}) || (FLASH_EN && (state == FL));
    case (state)
      MG:      succ = M2Y;
      M2Y:     succ = TG;
      TG:      succ = TY;
      TY:      succ = (req_pend || side_req) ? SG : AR;
      SG:      succ = AR;
      AR:      succ = MG;
      default: succ = AR;
    endcase
    // Flash overrides the normal successor at any phase end; leaving FL always goes via AR.
    if (flash_req && state != FL)
      succ = FL;
    go = tick && ((state == FL) ? !flash_req : (timer == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= AR;
      presc    <= '0;
      timer    <= TW'(T_AR - 1);
      lamps    <= {L_R, L_R, L_R, L_R};
      blink    <= 1'b1;
      req_pend <= 1'b0;
    end else begin
      presc <= (tick || !legal) ? '0 : presc + 1'b1;
      if (!legal) begin
        state <= AR;
        timer <= load(AR);
        lamps <= lamp_code(AR, 1'b1);
        blink <= 1'b1;
      end else if (go) begin
        state <= succ;
        timer <= load(succ);
        lamps <= lamp_code(succ, 1'b1);
        blink <= 1'b1;
      end else if (tick) begin
        if (state == FL) begin
          blink <= ~blink;
          lamps <= lamp_code(FL, ~blink);
        end else begin
          timer <= timer - 1'b1;
        end
      end
      // Clearing on SG entry beats a simultaneous new request.
      if (legal && go && succ == SG)
        req_pend <= 1'b0;
      else if (side_req)
        req_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tlc_param_junction.sv
// Bench for tlc_param_junction: phase-schedule model checked every cycle plus literal phase lengths.
// Flash scenario runs only when TLC_FLASH_EN is defined.
module tb_tlc_param_junction;

  localparam int TD = 4;
  localparam int T_MG = 7, T_Y = 2, T_TG = 5, T_SG = 3, T_AR = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       side_req;
  logic       flash;
  logic [2:0] light_M1, light_M2, light_MT, light_S, phase;
  logic       tick, req_pend;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  tlc_param_junction dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .side_req (side_req),
`ifdef TLC_FLASH_EN
    .flash    (flash),
`endif
    .light_M1 (light_M1),
    .light_M2 (light_M2),
    .light_MT (light_MT),
    .light_S  (light_S),
    .phase    (phase),
    .tick     (tick),
    .req_pend (req_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase index, cycles elapsed in phase, latched demand, flash lamp state.
  int m_st, m_e;
  bit m_req, m_lit;

  function automatic int dur(int s);
    case (s)
      0:       return T_MG * TD;
      1, 3:    return T_Y * TD;
      2:       return T_TG * TD;
      4:       return T_SG * TD;
      default: return T_AR * TD;
    endcase
  endfunction

  function automatic logic [11:0] exp_lamps(int s, bit lit);
    case (s)
      0:       return 12'b001_001_100_100;
      1:       return 12'b001_010_100_100;
      2:       return 12'b001_100_001_100;
      3:       return 12'b010_100_010_100;
      4:       return 12'b100_100_100_001;
      6:       return lit ? 12'b010_010_010_100 : 12'b000_000_000_000;
      default: return 12'b100_100_100_100;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 5; m_e = 0; m_req = 0; m_lit = 1;
    end else begin
      int nx;
      nx = -1;
      if (m_st == 6) begin
        if (m_e % TD == TD - 1) begin
          if (!flash) nx = 5;
          else m_lit = !m_lit;
        end
      end else if (m_e == dur(m_st) - 1) begin
        case (m_st)
          0: nx = 1;
          1: nx = 2;
          2: nx = 3;
          3: nx = (m_req || side_req) ? 4 : 5;
          4: nx = 5;
          default: nx = 0;
        endcase
        if (flash) nx = 6;
      end
      if (nx == 4) m_req = 0;
      else if (side_req) m_req = 1;
      if (nx >= 0) begin m_st = nx; m_e = 0; m_lit = 1; end
      else m_e++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("model_lamps", {20'd0, light_M1, light_M2, light_MT, light_S}, {20'd0, exp_lamps(m_st, m_lit)});
      chk("model_phase", {29'd0, phase}, m_st);
      chk("model_tick", {31'd0, tick}, {31'd0, (m_e % TD) == TD - 1});
      chk("model_req", {31'd0, req_pend}, {31'd0, m_req});
    end
  end

  task automatic measure(input logic [2:0] p, input int exp_len, input string nm);
    int n = 0;
    while (phase == p && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, exp_len);
  endtask

  task automatic wait_phase(input logic [2:0] p, input string nm);
    int n = 0;
    while (phase != p && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(nm, {29'd0, phase}, {29'd0, p});
  endtask

  initial begin
    rst_n = 1'b0; side_req = 1'b0; flash = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lamps", {20'd0, light_M1, light_M2, light_MT, light_S}, 32'b100_100_100_100);
    chk("rst_phase", {29'd0, phase}, 32'd5);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_req", {31'd0, req_pend}, 32'd0);
    cmp_en = 1'b1;
    rst_n = 1'b1;

    // Round 1: no demand, TY goes straight to AR.
    measure(3'd5, 8, "r1_ar_len");
    chk("r1_mg_lamps", {20'd0, light_M1, light_M2, light_MT, light_S}, 32'b001_001_100_100);
    measure(3'd0, 28, "r1_mg_len");
    measure(3'd1, 8, "r1_m2y_len");
    measure(3'd2, 20, "r1_tg_len");
    measure(3'd3, 8, "r1_ty_len");
    chk("r1_ty_to_ar", {29'd0, phase}, 32'd5);
    measure(3'd5, 8, "r1_ar2_len");

    // Round 2: one-cycle pulse during MG gets SG service.
    side_req = 1'b1;
    @(negedge clk);
    side_req = 1'b0;
    chk("r2_req_latched", {31'd0, req_pend}, 32'd1);
    measure(3'd0, 27, "r2_mg_rest");
    measure(3'd1, 8, "r2_m2y_len");
    measure(3'd2, 20, "r2_tg_len");
    measure(3'd3, 8, "r2_ty_len");
    chk("r2_sg_phase", {29'd0, phase}, 32'd4);
    chk("r2_sg_S", {29'd0, light_S}, 32'b001);
    chk("r2_req_clr", {31'd0, req_pend}, 32'd0);
    measure(3'd4, 12, "r2_sg_len");
    measure(3'd5, 8, "r2_ar_len");

    // Round 3: request held through SG entry re-latches one cycle later.
    side_req = 1'b1;
    measure(3'd0, 28, "r3_mg_len");
    measure(3'd1, 8, "r3_m2y_len");
    measure(3'd2, 20, "r3_tg_len");
    measure(3'd3, 8, "r3_ty_len");
    chk("r3_sg_phase", {29'd0, phase}, 32'd4);
    chk("r3_req_entry", {31'd0, req_pend}, 32'd0);
    @(negedge clk);
    chk("r3_req_relatch", {31'd0, req_pend}, 32'd1);
    measure(3'd4, 11, "r3_sg_rest");
    side_req = 1'b0;
    measure(3'd5, 8, "r3_ar_len");

    // Round 4: served again from the re-latched demand.
    measure(3'd0, 28, "r4_mg_len");
    measure(3'd1, 8, "r4_m2y_len");
    measure(3'd2, 20, "r4_tg_len");
    measure(3'd3, 8, "r4_ty_len");
    chk("r4_sg_again", {29'd0, phase}, 32'd4);
    measure(3'd4, 12, "r4_sg_len");
    measure(3'd5, 8, "r4_ar_len");

    // Round 5: async reset pulse mid-TG.
    measure(3'd0, 28, "r5_mg_len");
    measure(3'd1, 8, "r5_m2y_len");
    chk("r5_tg_phase", {29'd0, phase}, 32'd2);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("r5_rst_lamps", {20'd0, light_M1, light_M2, light_MT, light_S}, 32'b100_100_100_100);
    chk("r5_rst_phase", {29'd0, phase}, 32'd5);
    chk("r5_rst_tick", {31'd0, tick}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    measure(3'd5, 8, "r5_ar_len");
    chk("r5_mg_after", {29'd0, phase}, 32'd0);

`ifdef TLC_FLASH_EN
    flash = 1'b1;
    measure(3'd0, 28, "fl_mg_len");
    chk("fl_phase", {29'd0, phase}, 32'd6);
    chk("fl_lit", {20'd0, light_M1, light_M2, light_MT, light_S}, 32'b010_010_010_100);
    repeat (4) @(negedge clk);
    chk("fl_dark", {20'd0, light_M1, light_M2, light_MT, light_S}, 32'd0);
    repeat (4) @(negedge clk);
    chk("fl_relit", {29'd0, light_M1}, 32'b010);
    flash = 1'b0;
    wait_phase(3'd5, "fl_exit_ar");
    measure(3'd5, 8, "fl_ar_len");
    chk("fl_mg_after", {29'd0, phase}, 32'd0);
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
